// File: rtl/bias_loader_l17_pkg.sv
// Shared layer-17 bias path definitions: word width, FSM encoding and the
// default bank geometry also used by the 16:1 bias selector.
package L17_pkg;

    localparam int unsigned BIAS_W           = 18;
    localparam int unsigned DEF_N_ADDER_TREE = 16;
    localparam int unsigned DEF_N_BANK       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } l17_state_t;

endpackage

// File: rtl/bias_loader_l17_addr_cnt.sv
// Lane/bank write-address counter pair for the layer-17 bias loader.
// Lane counts fastest; bank advances when the lane wraps.
module bias_addr_cnt_L17
    import L17_pkg::*;
#(
    parameter int unsigned N_LANE = DEF_N_ADDER_TREE,
    parameter int unsigned N_BANK = DEF_N_BANK,
    parameter int unsigned LANE_W = (N_LANE > 1) ? $clog2(N_LANE) : 1,
    parameter int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [LANE_W-1:0] o_lane,
    output logic [BANK_W-1:0] o_bank,
    output logic              o_last
);

    logic [LANE_W-1:0] r_lane;
    logic [BANK_W-1:0] r_bank;
    logic              w_lane_wrap;
    logic              w_bank_wrap;

    assign w_lane_wrap = (r_lane == LANE_W'(N_LANE - 1));
    assign w_bank_wrap = (r_bank == BANK_W'(N_BANK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_bank <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_bank <= '0;
        end else if (i_inc) begin
            if (w_lane_wrap) begin
                r_lane <= '0;
                r_bank <= w_bank_wrap ? '0 : r_bank + 1'b1;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    assign o_lane = r_lane;
    assign o_bank = r_bank;
    assign o_last = w_lane_wrap && w_bank_wrap;

endmodule

// File: rtl/bias_loader_l17.sv
// Layer-17 bias table loader: fills N_BANK banks of N_adder_tree 18-bit lanes
// from a valid/ready word stream, then flags the table as loaded.
module bias_loader_l17
    import L17_pkg::*;
#(
    parameter int unsigned N_adder_tree = DEF_N_ADDER_TREE,
    parameter int unsigned N_BANK       = DEF_N_BANK
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [BIAS_W-1:0]                     in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [N_BANK*N_adder_tree*BIAS_W-1:0] bank_flat,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  loaded
);

    localparam int unsigned LANE_W = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
    localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;

    l17_state_t                            r_state;
    l17_state_t                            w_state_nxt;
    logic                                  w_clear;
    logic                                  w_wr;
    logic                                  w_last;
    logic [LANE_W-1:0]                     w_lane;
    logic [BANK_W-1:0]                     w_bank;
    logic                                  r_loaded;
    logic [N_BANK*N_adder_tree*BIAS_W-1:0] r_bank_flat;

    // A handshake coinciding with start is dropped so the restart begins at lane 0.
    assign w_wr    = (r_state == ST_LOAD) && in_valid && !start;
    assign w_clear = start && (r_state != ST_DONE);

    bias_addr_cnt_L17 #(
        .N_LANE (N_adder_tree),
        .N_BANK (N_BANK)
    ) u_addr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_inc   (w_wr),
        .o_lane  (w_lane),
        .o_bank  (w_bank),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (start)               w_state_nxt = ST_LOAD;
                else if (w_wr && w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_LOAD);
        busy     = (r_state == ST_LOAD);
        done     = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_loaded <= 1'b0;
        else if (w_clear)        r_loaded <= 1'b0;
        else if (w_wr && w_last) r_loaded <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_flat <= '0;
        end else if (w_wr) begin
            for (int unsigned k = 0; k < N_BANK; k++) begin
                for (int unsigned j = 0; j < N_adder_tree; j++) begin
                    if (w_bank == BANK_W'(k) && w_lane == LANE_W'(j))
                        r_bank_flat[(k*N_adder_tree + j)*BIAS_W +: BIAS_W] <= in_data;
                end
            end
        end
    end

    assign bank_flat = r_bank_flat;
    assign loaded    = r_loaded;

endmodule
